// File: rtl/tx_rd_req_tlp_gen_if.sv
// TX TRN bus plus the shared-bus arbitration handshake, as seen by one TLP source.
// master = TLP source (drives frame and request); slave = core/arbiter side.
interface tx_rd_req_tlp_gen_if;
  logic        tx_req;
  logic        tx_grant;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [3:0]  trn_tbuf_av;
  logic        trn_tsrc_dsc_n;

  modport master (
    output tx_req,
    output trn_td,
    output trn_trem_n,
    output trn_tsof_n,
    output trn_teof_n,
    output trn_tsrc_rdy_n,
    output trn_tsrc_dsc_n,
    input  tx_grant,
    input  trn_tdst_rdy_n,
    input  trn_tbuf_av
  );

  modport slave (
    input  tx_req,
    input  trn_td,
    input  trn_trem_n,
    input  trn_tsof_n,
    input  trn_teof_n,
    input  trn_tsrc_rdy_n,
    input  trn_tsrc_dsc_n,
    output tx_grant,
    output trn_tdst_rdy_n,
    output trn_tbuf_av
  );
endinterface

// File: rtl/tx_rd_req_tlp_gen.sv
// Splits one CHUNK_BYTES host read into MRd64 TLPs no larger than MRRS and
// issues them on the shared TX TRN bus, acknowledging the chunk when done.
module tx_rd_req_tlp_gen #(
  parameter int CHUNK_BYTES = 512,
  parameter int TAG_W       = 5
) (
  input  logic                trn_clk,
  input  logic                reset_n,
  input  logic                read_chunk,
  input  logic [63:0]         huge_page_addr_read_from,
  output logic                read_chunk_ack,
  input  logic [7:0]          cfg_bus_number,
  input  logic [4:0]          cfg_device_number,
  input  logic [2:0]          cfg_function_number,
  input  logic [15:0]         cfg_dcommand,
  tx_rd_req_tlp_gen_if.master tx
);

  localparam int CNT_W = $clog2(CHUNK_BYTES / 128) + 1;

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    ARB      = 7'b0000010,
    CHK      = 7'b0000100,
    HDR1     = 7'b0001000,
    HDR2     = 7'b0010000,
    ACK      = 7'b0100000,
    WAIT_LOW = 7'b1000000
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [9:0]       size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      td_q, td_d;
  logic             sof_n_q, sof_n_d;
  logic             eof_n_q, eof_n_d;
  logic             src_rdy_n_q, src_rdy_n_d;
  logic             req_q, req_d;
  logic             ack_q, ack_d;

  logic [31:0]      dw0;
  logic [31:0]      dw1;
  logic             beat_taken;
  logic             unused_ok;

  // MRRS codes above 512 B are clamped; a small chunk further caps the request.
  function automatic logic [9:0] req_size_f(input logic [2:0] mrrs);
    logic [9:0] b;
    case (mrrs)
      3'b000:  b = 10'd128;
      3'b001:  b = 10'd256;
      default: b = 10'd512;
    endcase
    if (int'(b) > CHUNK_BYTES) b = 10'(CHUNK_BYTES);
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] req_count_f(input logic [9:0] size);
    logic [CNT_W-1:0] n;
    case (size)
      10'd128: n = CNT_W'(CHUNK_BYTES / 128);
      10'd256: n = CNT_W'(CHUNK_BYTES / 256);
      default: n = CNT_W'(CHUNK_BYTES / 512);
    endcase
    return n;
  endfunction

  always_comb begin
    dw0 = {1'b0, 2'b01, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
           {2'b00, size_q[9:2]}};
    dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number, 8'(tag_q), 4'hF, 4'hF};
  end

  assign beat_taken = !src_rdy_n_q && !tx.trn_tdst_rdy_n;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    td_d        = td_q;
    sof_n_d     = sof_n_q;
    eof_n_d     = eof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    req_d       = req_q;
    ack_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_chunk) begin
          addr_d  = huge_page_addr_read_from;
          size_d  = req_size_f(cfg_dcommand[14:12]);
          cnt_d   = req_count_f(size_d);
          req_d   = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (tx.tx_grant) state_d = CHK;
      end
      CHK: begin
        if (tx.trn_tbuf_av[1] && !tx.trn_tdst_rdy_n) begin
          td_d        = {dw0, dw1};
          sof_n_d     = 1'b0;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b0;
          state_d     = HDR1;
        end
      end
      HDR1: begin
        if (beat_taken) begin
          td_d    = {addr_q[63:32], addr_q[31:2], 2'b00};
          sof_n_d = 1'b1;
          eof_n_d = 1'b0;
          state_d = HDR2;
        end
      end
      HDR2: begin
        if (beat_taken) begin
          src_rdy_n_d = 1'b1;
          eof_n_d     = 1'b1;
          tag_d       = tag_q + TAG_W'(1);
          addr_d      = addr_q + 64'(size_q);
          cnt_d       = cnt_q - CNT_W'(1);
          // The bus is kept between sub-requests; only the last one releases it.
          if (cnt_q == CNT_W'(1)) begin
            req_d   = 1'b0;
            state_d = ACK;
          end else begin
            state_d = CHK;
          end
        end
      end
      ACK: begin
        ack_d   = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!read_chunk) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      td_q        <= '0;
      sof_n_q     <= 1'b1;
      eof_n_q     <= 1'b1;
      src_rdy_n_q <= 1'b1;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      td_q        <= td_d;
      sof_n_q     <= sof_n_d;
      eof_n_q     <= eof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
    end
  end

  assign read_chunk_ack     = ack_q;
  assign tx.tx_req          = req_q;
  assign tx.trn_td          = td_q;
  assign tx.trn_trem_n      = 8'h00;
  assign tx.trn_tsof_n      = sof_n_q;
  assign tx.trn_teof_n      = eof_n_q;
  assign tx.trn_tsrc_rdy_n  = src_rdy_n_q;
  assign tx.trn_tsrc_dsc_n  = 1'b1;

  assign unused_ok = ^{cfg_dcommand[15], cfg_dcommand[11:0], tx.trn_tbuf_av[3:2], tx.trn_tbuf_av[0]};

endmodule

// File: tb/tb_tx_rd_req_tlp_gen.sv
// Directed bench for tx_rd_req_tlp_gen: a negedge monitor collects accepted
// beats and acks, and each scenario task compares them with hand-computed values.
module tb_tx_rd_req_tlp_gen;
  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_chunk = 1'b0;
  logic [63:0] huge_page_addr_read_from = '0;
  logic        read_chunk_ack;
  logic [7:0]  cfg_bus_number = 8'h02;
  logic [4:0]  cfg_device_number = 5'd0;
  logic [2:0]  cfg_function_number = 3'd0;
  logic [15:0] cfg_dcommand = 16'h2000;
  logic        grant_force = 1'b0;
  logic        grant_val = 1'b0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  tx_rd_req_tlp_gen_if bus ();
  assign bus.tx_grant = grant_force ? grant_val : bus.tx_req;

  always #5 trn_clk = ~trn_clk;
  always @(posedge trn_clk) cyc <= cyc + 1;

  tx_rd_req_tlp_gen #(.CHUNK_BYTES(512), .TAG_W(5)) dut (
    .trn_clk                  (trn_clk),
    .reset_n                  (reset_n),
    .read_chunk               (read_chunk),
    .huge_page_addr_read_from (huge_page_addr_read_from),
    .read_chunk_ack           (read_chunk_ack),
    .cfg_bus_number           (cfg_bus_number),
    .cfg_device_number        (cfg_device_number),
    .cfg_function_number      (cfg_function_number),
    .cfg_dcommand             (cfg_dcommand),
    .tx                       (bus)
  );

  // Monitor: sole writer of the collected beats and event counters.
  logic [63:0] mon_td[$];
  bit          mon_sof[$];
  bit          mon_eof[$];
  int          mon_cyc[$];
  int          ack_cnt = 0, stab_err = 0, trem_err = 0, req_fall = 0, req_low_err = 0;
  bit          stall_prev = 0, prev_req = 0;
  logic [63:0] prev_td = '0;
  logic        prev_sof = 1'b1, prev_eof = 1'b1;

  always @(negedge trn_clk) begin
    if (!reset_n) begin
      stall_prev = 0;
      prev_req   = 0;
    end else begin
      if (bus.trn_tsrc_rdy_n === 1'b0) begin
        if (stall_prev && (bus.trn_td !== prev_td || bus.trn_tsof_n !== prev_sof ||
                           bus.trn_teof_n !== prev_eof)) stab_err++;
        if (bus.trn_trem_n !== 8'h00) trem_err++;
        if (bus.tx_req !== 1'b1) req_low_err++;
        if (bus.trn_tdst_rdy_n === 1'b0) begin
          mon_td.push_back(bus.trn_td);
          mon_sof.push_back(bus.trn_tsof_n);
          mon_eof.push_back(bus.trn_teof_n);
          mon_cyc.push_back(cyc);
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          prev_td    = bus.trn_td;
          prev_sof   = bus.trn_tsof_n;
          prev_eof   = bus.trn_teof_n;
        end
      end else begin
        stall_prev = 0;
      end
      if (read_chunk_ack === 1'b1) ack_cnt++;
      if (prev_req && bus.tx_req === 1'b0) req_fall++;
      prev_req = (bus.tx_req === 1'b1);
    end
  end

  task automatic wait_ack(input int budget, output bit ok, output int at);
    ok = 0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge trn_clk); #1;
      if (read_chunk_ack === 1'b1) begin
        ok = 1;
        at = cyc;
        break;
      end
    end
  endtask

  // Keeps read_chunk high one cycle past the ack, then drops it and idles.
  task automatic release_chunk();
    @(posedge trn_clk); #1;
    @(posedge trn_clk); #1;
    read_chunk = 1'b0;
    repeat (2) begin @(posedge trn_clk); #1; end
  endtask

  task automatic apply_reset();
    read_chunk = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge trn_clk);
    #1 reset_n = 1'b1;
    @(posedge trn_clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge trn_clk);
    #1;
    total++; if (bus.tx_req !== 1'b0) $display("FAIL reset_tx_req got=%b want=0", bus.tx_req); else passed++;
    total++; if (read_chunk_ack !== 1'b0) $display("FAIL reset_ack got=%b want=0", read_chunk_ack); else passed++;
    total++; if (bus.trn_tsof_n !== 1'b1) $display("FAIL reset_sof_n got=%b want=1", bus.trn_tsof_n); else passed++;
    total++; if (bus.trn_teof_n !== 1'b1) $display("FAIL reset_eof_n got=%b want=1", bus.trn_teof_n); else passed++;
    total++; if (bus.trn_tsrc_rdy_n !== 1'b1) $display("FAIL reset_src_rdy_n got=%b want=1", bus.trn_tsrc_rdy_n); else passed++;
    total++; if (bus.trn_tsrc_dsc_n !== 1'b1) $display("FAIL reset_dsc_n got=%b want=1", bus.trn_tsrc_dsc_n); else passed++;
    total++; if (bus.trn_td !== 64'h0) $display("FAIL reset_td got=%h want=0", bus.trn_td); else passed++;
    total++; if (bus.trn_trem_n !== 8'h00) $display("FAIL reset_trem_n got=%h want=00", bus.trn_trem_n); else passed++;
    reset_n = 1'b1;
    @(posedge trn_clk); #1;
  endtask

  task automatic test_single_512();
    int b0, a0, c0, at;
    bit ok;
    b0 = mon_td.size();
    a0 = ack_cnt;
    cfg_dcommand = 16'h2000;
    huge_page_addr_read_from = 64'h0000_0001_2345_6000;
    read_chunk = 1'b1;
    c0 = cyc;
    wait_ack(40, ok, at);
    total++; if (ok !== 1'b1) $display("FAIL single_ack_seen got=%b want=1", ok); else passed++;
    total++; if (at - c0 !== 6) $display("FAIL single_ack_latency got=%0d want=6", at - c0); else passed++;
    release_chunk();
    total++; if (mon_td.size() - b0 !== 2) $display("FAIL single_beats got=%0d want=2", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 2) begin
      total++; if (mon_td[b0] !== 64'h20000080_020000FF) $display("FAIL single_beat1 got=%h want=20000080020000ff", mon_td[b0]); else passed++;
      total++; if (mon_sof[b0] !== 1'b0 || mon_eof[b0] !== 1'b1) $display("FAIL single_beat1_flags got=sof%b/eof%b want=sof0/eof1", mon_sof[b0], mon_eof[b0]); else passed++;
      total++; if (mon_cyc[b0] - c0 !== 3) $display("FAIL single_sof_latency got=%0d want=3", mon_cyc[b0] - c0); else passed++;
      total++; if (mon_td[b0+1] !== 64'h00000001_23456000) $display("FAIL single_beat2 got=%h want=0000000123456000", mon_td[b0+1]); else passed++;
      total++; if (mon_sof[b0+1] !== 1'b1 || mon_eof[b0+1] !== 1'b0) $display("FAIL single_beat2_flags got=sof%b/eof%b want=sof1/eof0", mon_sof[b0+1], mon_eof[b0+1]); else passed++;
    end
    total++; if (ack_cnt - a0 !== 1) $display("FAIL single_ack_count got=%0d want=1", ack_cnt - a0); else passed++;
    total++; if (trem_err !== 0) $display("FAIL single_trem got=%0d bad beats want=0", trem_err); else passed++;
  endtask

  task automatic test_mrrs128();
    int b0, a0, f0, at;
    bit ok;
    logic [63:0] exp_addr;
    b0 = mon_td.size();
    a0 = ack_cnt;
    f0 = req_fall;
    cfg_dcommand = 16'h0000;
    huge_page_addr_read_from = 64'h0000_0001_2345_6000;
    read_chunk = 1'b1;
    wait_ack(80, ok, at);
    total++; if (ok !== 1'b1) $display("FAIL mrrs128_ack_seen got=%b want=1", ok); else passed++;
    release_chunk();
    total++; if (mon_td.size() - b0 !== 8) $display("FAIL mrrs128_beats got=%0d want=8", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 8) begin
      for (int i = 0; i < 4; i++) begin
        exp_addr = 64'h0000_0001_2345_6000 + 64'(i) * 64'h80;
        total++; if (mon_td[b0+2*i][63:32] !== 32'h20000020) $display("FAIL mrrs128_dw0_%0d got=%h want=20000020", i, mon_td[b0+2*i][63:32]); else passed++;
        total++; if (mon_td[b0+2*i][15:8] !== 8'(i + 1)) $display("FAIL mrrs128_tag_%0d got=%0d want=%0d", i, mon_td[b0+2*i][15:8], i + 1); else passed++;
        total++; if (mon_td[b0+2*i+1] !== exp_addr) $display("FAIL mrrs128_addr_%0d got=%h want=%h", i, mon_td[b0+2*i+1], exp_addr); else passed++;
      end
      total++; if (at - mon_cyc[b0+7] !== 2) $display("FAIL mrrs128_ack_after_eof got=%0d want=2", at - mon_cyc[b0+7]); else passed++;
    end
    total++; if (ack_cnt - a0 !== 1) $display("FAIL mrrs128_ack_count got=%0d want=1", ack_cnt - a0); else passed++;
    total++; if (req_fall - f0 !== 1) $display("FAIL mrrs128_req_drops got=%0d want=1", req_fall - f0); else passed++;
  endtask

  task automatic test_stall();
    int b0, a0, s0, at;
    bit ok, seen;
    b0 = mon_td.size();
    a0 = ack_cnt;
    s0 = stab_err;
    seen = 0;
    cfg_dcommand = 16'h2000;
    huge_page_addr_read_from = 64'h0000_0000_ABCD_0200;
    read_chunk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge trn_clk); #1;
      if (bus.trn_tsof_n === 1'b0) begin seen = 1; break; end
    end
    bus.trn_tdst_rdy_n = 1'b1;
    total++; if (seen !== 1'b1) $display("FAIL stall_sof_seen got=%b want=1", seen); else passed++;
    repeat (5) begin @(posedge trn_clk); #1; end
    total++; if (bus.trn_tsof_n !== 1'b0 || bus.trn_td !== 64'h20000080_020005FF) $display("FAIL stall_beat1_hold got=sof%b td=%h want=sof0 td=20000080020005ff", bus.trn_tsof_n, bus.trn_td); else passed++;
    bus.trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    bus.trn_tdst_rdy_n = 1'b1;
    repeat (3) begin @(posedge trn_clk); #1; end
    total++; if (bus.trn_teof_n !== 1'b0 || bus.trn_td !== 64'h00000000_ABCD0200) $display("FAIL stall_beat2_hold got=eof%b td=%h want=eof0 td=00000000abcd0200", bus.trn_teof_n, bus.trn_td); else passed++;
    bus.trn_tdst_rdy_n = 1'b0;
    wait_ack(40, ok, at);
    total++; if (ok !== 1'b1) $display("FAIL stall_ack_seen got=%b want=1", ok); else passed++;
    release_chunk();
    total++; if (mon_td.size() - b0 !== 2) $display("FAIL stall_beats got=%0d want=2", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 2) begin
      total++; if (mon_td[b0] !== {32'h20000080, 8'h02, 5'd0, 3'd0, 8'd5, 8'hFF}) $display("FAIL stall_beat1 got=%h want=20000080020005ff", mon_td[b0]); else passed++;
      total++; if (mon_td[b0+1] !== 64'h00000000_ABCD0200) $display("FAIL stall_beat2 got=%h want=00000000abcd0200", mon_td[b0+1]); else passed++;
    end
    total++; if (stab_err - s0 !== 0) $display("FAIL stall_stability got=%0d changes want=0", stab_err - s0); else passed++;
    total++; if (ack_cnt - a0 !== 1) $display("FAIL stall_ack_count got=%0d want=1", ack_cnt - a0); else passed++;
  endtask

  task automatic test_credit_grant();
    int b0, a0, ts, sof_at, sof_early, req_low, at;
    bit ok;
    b0 = mon_td.size();
    a0 = ack_cnt;
    sof_early = 0;
    req_low = 0;
    sof_at = -1;
    grant_force = 1'b1;
    grant_val = 1'b0;
    bus.trn_tbuf_av = 4'b1101;
    cfg_dcommand = 16'h1000;
    huge_page_addr_read_from = 64'h0000_0000_FFFF_FE00;
    read_chunk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge trn_clk); #1;
      if (bus.trn_tsof_n !== 1'b1) sof_early++;
      if (bus.tx_req !== 1'b1) req_low++;
      if (i == 7) grant_val = 1'b1;
    end
    bus.trn_tbuf_av = 4'hF;
    ts = cyc;
    for (int i = 0; i < 10; i++) begin
      @(posedge trn_clk); #1;
      if (bus.trn_tsof_n === 1'b0) begin sof_at = cyc; break; end
    end
    total++; if (sof_early !== 0) $display("FAIL credit_no_early_sof got=%0d want=0", sof_early); else passed++;
    total++; if (req_low !== 0) $display("FAIL credit_req_held got=%0d low cycles want=0", req_low); else passed++;
    total++; if (sof_at - ts !== 1) $display("FAIL credit_sof_latency got=%0d want=1", sof_at - ts); else passed++;
    wait_ack(60, ok, at);
    total++; if (ok !== 1'b1) $display("FAIL credit_ack_seen got=%b want=1", ok); else passed++;
    release_chunk();
    grant_force = 1'b0;
    total++; if (mon_td.size() - b0 !== 4) $display("FAIL credit_beats got=%0d want=4", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 4) begin
      total++; if (mon_td[b0] !== 64'h20000040_020006FF) $display("FAIL credit_tlp0_hdr got=%h want=20000040020006ff", mon_td[b0]); else passed++;
      total++; if (mon_td[b0+1] !== 64'h00000000_FFFFFE00) $display("FAIL credit_tlp0_addr got=%h want=00000000fffffe00", mon_td[b0+1]); else passed++;
      total++; if (mon_td[b0+2] !== 64'h20000040_020007FF) $display("FAIL credit_tlp1_hdr got=%h want=20000040020007ff", mon_td[b0+2]); else passed++;
      total++; if (mon_td[b0+3] !== 64'h00000000_FFFFFF00) $display("FAIL credit_tlp1_addr got=%h want=00000000ffffff00", mon_td[b0+3]); else passed++;
    end
    total++; if (ack_cnt - a0 !== 1) $display("FAIL credit_ack_count got=%0d want=1", ack_cnt - a0); else passed++;
  endtask

  task automatic test_tag_wrap();
    int b0, a0, at, miss;
    bit ok;
    logic [63:0] exp_addr;
    apply_reset();
    b0 = mon_td.size();
    a0 = ack_cnt;
    miss = 0;
    cfg_dcommand = 16'h2000;
    for (int k = 0; k < 40; k++) begin
      huge_page_addr_read_from = 64'h0000_0002_0000_0000 + 64'(k) * 64'd512;
      read_chunk = 1'b1;
      wait_ack(40, ok, at);
      if (!ok) miss++;
      release_chunk();
    end
    total++; if (miss !== 0) $display("FAIL wrap_acks_missing got=%0d want=0", miss); else passed++;
    total++; if (ack_cnt - a0 !== 40) $display("FAIL wrap_ack_count got=%0d want=40", ack_cnt - a0); else passed++;
    total++; if (mon_td.size() - b0 !== 80) $display("FAIL wrap_beats got=%0d want=80", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 80) begin
      for (int k = 0; k < 40; k++) begin
        exp_addr = 64'h0000_0002_0000_0000 + 64'(k) * 64'd512;
        total++; if (mon_td[b0+2*k][15:8] !== 8'(k % 32)) $display("FAIL wrap_tag_%0d got=%0d want=%0d", k, mon_td[b0+2*k][15:8], k % 32); else passed++;
        total++; if (mon_td[b0+2*k+1] !== exp_addr) $display("FAIL wrap_addr_%0d got=%h want=%h", k, mon_td[b0+2*k+1], exp_addr); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int b0, a0, at;
    bit ok, seen;
    seen = 0;
    cfg_dcommand = 16'h2000;
    huge_page_addr_read_from = 64'h0000_0003_0000_0400;
    read_chunk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge trn_clk); #1;
      if (bus.trn_teof_n === 1'b0) begin seen = 1; break; end
    end
    bus.trn_tdst_rdy_n = 1'b1;
    total++; if (seen !== 1'b1) $display("FAIL rstmid_hdr2_reached got=%b want=1", seen); else passed++;
    @(posedge trn_clk); #1;
    reset_n = 1'b0;
    #2;
    total++; if (bus.tx_req !== 1'b0) $display("FAIL rstmid_tx_req got=%b want=0", bus.tx_req); else passed++;
    total++; if (bus.trn_teof_n !== 1'b1) $display("FAIL rstmid_eof_n got=%b want=1", bus.trn_teof_n); else passed++;
    total++; if (bus.trn_tsof_n !== 1'b1) $display("FAIL rstmid_sof_n got=%b want=1", bus.trn_tsof_n); else passed++;
    total++; if (bus.trn_tsrc_rdy_n !== 1'b1) $display("FAIL rstmid_src_rdy_n got=%b want=1", bus.trn_tsrc_rdy_n); else passed++;
    total++; if (bus.trn_td !== 64'h0) $display("FAIL rstmid_td got=%h want=0", bus.trn_td); else passed++;
    total++; if (read_chunk_ack !== 1'b0) $display("FAIL rstmid_ack got=%b want=0", read_chunk_ack); else passed++;
    bus.trn_tdst_rdy_n = 1'b0;
    huge_page_addr_read_from = 64'h0000_0003_0000_0600;
    b0 = mon_td.size();
    a0 = ack_cnt;
    @(posedge trn_clk); #1;
    reset_n = 1'b1;
    wait_ack(40, ok, at);
    total++; if (ok !== 1'b1) $display("FAIL rstmid_ack_seen got=%b want=1", ok); else passed++;
    release_chunk();
    total++; if (mon_td.size() - b0 !== 2) $display("FAIL rstmid_beats got=%0d want=2", mon_td.size() - b0); else passed++;
    if (mon_td.size() - b0 >= 2) begin
      total++; if (mon_td[b0] !== 64'h20000080_020000FF) $display("FAIL rstmid_beat1 got=%h want=20000080020000ff", mon_td[b0]); else passed++;
      total++; if (mon_td[b0+1] !== 64'h00000003_00000600) $display("FAIL rstmid_beat2 got=%h want=0000000300000600", mon_td[b0+1]); else passed++;
    end
    total++; if (ack_cnt - a0 !== 1) $display("FAIL rstmid_ack_count got=%0d want=1", ack_cnt - a0); else passed++;
  endtask

  task automatic test_bus_integrity();
    total++; if (stab_err !== 0) $display("FAIL bus_beat_stability got=%0d want=0", stab_err); else passed++;
    total++; if (trem_err !== 0) $display("FAIL bus_trem got=%0d want=0", trem_err); else passed++;
    total++; if (req_low_err !== 0) $display("FAIL bus_req_during_beat got=%0d want=0", req_low_err); else passed++;
  endtask

  initial begin
    bus.trn_tdst_rdy_n = 1'b0;
    bus.trn_tbuf_av    = 4'hF;
    test_reset();
    test_single_512();
    test_mrrs128();
    test_stall();
    test_credit_grant();
    test_tag_wrap();
    test_reset_mid();
    test_bus_integrity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
